jtcps1_bank_arb: RTL

- Single-port SDRAM command scheduler for the CPS1/CPS2 memory subsystem.
- Accepts the four per-bank request channels from the slot multiplexers: bank 0 is R/W, banks 1–3 are read-only.
- Grants one channel at a time to the SDRAM core command port, routes ack/rdy back to the owning bank, and inserts auto-refresh cycles when the frame logic enables them.
- Sits between the slot multiplexer layer and the SDRAM core.

---
 rtl/jtcps1_arb_pkg.sv | 16 +
 rtl/jtcps1_rr_pick.sv | 27 ++
 rtl/jtcps1_bank_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/jtcps1_arb_pkg.sv
// Shared constants for the CPS1/CPS2 SDRAM bank arbiter.
package jtcps1_arb_pkg;

  localparam int unsigned NBANK = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RFSH  = 2'd3;

  localparam logic [1:0] BANK0 = 2'd0;
  localparam logic [1:0] BANK1 = 2'd1;
  localparam logic [1:0] BANK2 = 2'd2;
  localparam logic [1:0] BANK3 = 2'd3;

endpackage

// File: rtl/jtcps1_rr_pick.sv
// Rotating-priority encoder: first requester after rr, wrapping modulo 4.
module jtcps1_rr_pick
  import jtcps1_arb_pkg::*;
(
  input  logic [NBANK-1:0] req_i,
  input  logic [1:0]       rr_i,
  output logic [1:0]       gnt_o,
  output logic             any_o
);

  logic [1:0] idx;

  always_comb begin
    gnt_o = rr_i;
    any_o = 1'b0;
    idx   = 2'd0;
    // Offset 4 wraps back onto rr itself, so the last winner gets lowest priority.
    for (int k = 1; k <= 4; k++) begin
      idx = rr_i + 2'(k);
      if (!any_o && req_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtcps1_bank_arb.sv
// Single-port SDRAM command scheduler: round-robin grant of four bank channels
// to the SDRAM core, with ack/rdy routing, auto-refresh insertion and a watchdog.
module jtcps1_bank_arb
  import jtcps1_arb_pkg::*;
#(
  parameter int unsigned AW          = 23,
  parameter int unsigned RFSH_PERIOD = 380,
  parameter int unsigned TOUT        = 64,
  parameter int unsigned RFSH_W      = 9
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          refresh_en,
  input  logic [AW-1:0] ba0_addr,
  input  logic          ba0_rd,
  input  logic          ba0_wr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [2:0]    ba_rd,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_rdy,
  output logic [AW-1:0] cmd_addr,
  output logic [1:0]    cmd_ba,
  output logic          cmd_rd,
  output logic          cmd_wr,
  output logic [15:0]   cmd_din,
  output logic [1:0]    cmd_mask,
  output logic          cmd_rfsh,
  input  logic          cmd_ack,
  input  logic          cmd_rdy,
  output logic          busy,
  output logic          tout_err
);

  localparam int unsigned WD_W = (TOUT > 2) ? $clog2(TOUT) : 1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [1:0]       ba_q, ba_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [15:0]      din_q, din_d;
  logic [1:0]       mask_q, mask_d;
  logic             rfsh_q, rfsh_d;
  logic [RFSH_W-1:0] rfsh_cnt_q, rfsh_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             tout_q, tout_d;

  logic [NBANK-1:0] req;
  logic [1:0]       gnt;
  logic             any_req;
  logic             rfsh_due;

  assign req      = {ba_rd, ba0_rd | ba0_wr};
  assign rfsh_due = (rfsh_cnt_q == RFSH_W'(RFSH_PERIOD)) & refresh_en;

  jtcps1_rr_pick u_pick (
    .req_i (req),
    .rr_i  (rr_q),
    .gnt_o (gnt),
    .any_o (any_req)
  );

  // Next-state, command latching and per-bank ack/rdy routing.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    ba_d       = ba_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    din_d      = din_q;
    mask_d     = mask_q;
    rfsh_d     = rfsh_q;
    wd_d       = wd_q;
    tout_d     = tout_q;
    rfsh_cnt_d = rfsh_cnt_q;
    ba_ack     = 4'd0;
    ba_rdy     = 4'd0;

    if (rfsh_cnt_q != RFSH_W'(RFSH_PERIOD))
      rfsh_cnt_d = rfsh_cnt_q + RFSH_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (rfsh_due) begin
          state_d = ST_RFSH;
          rfsh_d  = 1'b1;
        end else if (any_req) begin
          state_d = ST_ISSUE;
          rr_d    = gnt;
          ba_d    = gnt;
          case (gnt)
            BANK0: begin
              addr_d = ba0_addr;
              din_d  = ba0_din;
              mask_d = ba0_din_m;
            end
            BANK1:   addr_d = ba1_addr;
            BANK2:   addr_d = ba2_addr;
            BANK3:   addr_d = ba3_addr;
            default: addr_d = ba3_addr;
          endcase
          wr_d = (gnt == BANK0) & ba0_wr;
          rd_d = ~((gnt == BANK0) & ba0_wr);
        end
      end
      ST_ISSUE: begin
        // A simultaneous cmd_rdy is deliberately ignored here.
        if (cmd_ack) begin
          ba_ack[ba_q] = 1'b1;
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          wd_d         = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cmd_rdy) begin
          ba_rdy[ba_q] = 1'b1;
          state_d      = ST_IDLE;
        end else if (wd_q == WD_W'(TOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_RFSH: begin
        if (cmd_ack) begin
          rfsh_d     = 1'b0;
          rfsh_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= BANK3;
      addr_q     <= '0;
      ba_q       <= BANK0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      din_q      <= '0;
      mask_q     <= '0;
      rfsh_q     <= 1'b0;
      rfsh_cnt_q <= '0;
      wd_q       <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      addr_q     <= addr_d;
      ba_q       <= ba_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      din_q      <= din_d;
      mask_q     <= mask_d;
      rfsh_q     <= rfsh_d;
      rfsh_cnt_q <= rfsh_cnt_d;
      wd_q       <= wd_d;
      tout_q     <= tout_d;
    end
  end

  assign cmd_addr = addr_q;
  assign cmd_ba   = ba_q;
  assign cmd_rd   = rd_q;
  assign cmd_wr   = wr_q;
  assign cmd_din  = din_q;
  assign cmd_mask = mask_q;
  assign cmd_rfsh = rfsh_q;
  assign busy     = (state_q != ST_IDLE);
  assign tout_err = tout_q;

endmodule
